// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: M-extension funct3 codes, MDU state encoding, width-derived constants.
// No logic; pure declarations and constant helpers.
// No handshake of its own.
package ex_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    typedef enum logic {
        MDU_MODE_MUL = 1'b0,
        MDU_MODE_DIV = 1'b1
    } mdu_mode_e;

    // All-ones value of an xlen-bit word (divide-by-zero quotient), returned in 64 bits.
    function automatic logic [63:0] mdu_all_ones(input int xlen);
        return (64'd1 << xlen) - 64'd1;
    endfunction

    // Most-negative xlen-bit two's-complement value, returned in 64 bits.
    function automatic logic [63:0] mdu_most_neg(input int xlen);
        return 64'd1 << (xlen - 1);
    endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// Execute-stage MDU port bundle: operands/op/start/flush in, stall/busy/done/result out.
// Latency is set by the unit behind the slave modport.
// The pipeline holds start and operands while stall is high.
interface ex_mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/mdu_iter.sv
// Shared shift/accumulate datapath: shift-add multiply or restoring divide, one bit per step.
// One bit per enabled cycle; acc_step shows the value the next step will write.
// No backpressure; the owner decides when to load and step.
module mdu_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  mdu_mode_e         mode,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic [2*XLEN-1:0] acc_step
);

    // acc[2X-1:X] is the running high product / partial remainder,
    // acc[X-1:0] holds the multiplier (shifting out) or dividend/quotient.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;

    // One iteration of the selected algorithm, computed from the current accumulator
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_trial - {1'b0, opnd};
        acc_step  = acc;
        if (mode == MDU_MODE_MUL) begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end else if (div_trial >= {1'b0, opnd}) begin
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    // Accumulator and second operand: load both magnitudes, then step in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{XLEN{1'b0}}, opa};
            opnd <= opb;
        end else if (step) begin
            acc  <= acc_step;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// RV32M iterative multiply/divide unit beside the EX-stage ALU, with registered result and done pulse.
// XLEN+1 cycles start-to-done for iterative ops; 1 cycle for special cases and fast multiply.
// Stalls the pipeline (stall = start && not DONE) until the result is presented.
module ex_mdu
    import ex_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic     clk,
    input  logic     rst,
    ex_mdu_if.slave  io
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [63:0]     ONES64   = mdu_all_ones(XLEN);
    localparam logic [63:0]     NEG64    = mdu_most_neg(XLEN);
    localparam logic [XLEN-1:0] ALL_ONES = ONES64[XLEN-1:0];
    localparam logic [XLEN-1:0] MOST_NEG = NEG64[XLEN-1:0];

    mdu_state_e        state;
    mdu_state_e        state_nxt;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   result_q;

    logic              a_sgn;
    logic              b_sgn;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div0;
    logic              ovf;
    logic              special;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   spec_res;

    logic              accept;
    logic              finish;
    logic              step;
    logic              load;
    mdu_mode_e         mode;
    logic [2*XLEN-1:0] acc_step;

    // Turns an unsigned magnitude result into the architectural result for op f.
    // nq: product/quotient negative; nr: remainder negative (dividend sign).
    function automatic logic [XLEN-1:0] fix_sign(input logic [2:0] f, input logic nq,
                                                 input logic nr, input logic [2*XLEN-1:0] raw);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = nq ? -raw : raw;
        quo  = raw[XLEN-1:0];
        rem  = raw[2*XLEN-1:XLEN];
        case (f)
            MDU_MUL:                 fix_sign = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU,
            MDU_MULHU:               fix_sign = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:       fix_sign = nq ? -quo : quo;
            default:                 fix_sign = nr ? -rem : rem;
        endcase
    endfunction

    // Operand signs, magnitudes and single-cycle special-case results for the op on the inputs
    always_comb begin
        a_sgn     = (io.op == MDU_MULH) || (io.op == MDU_MULHSU) ||
                    (io.op == MDU_DIV)  || (io.op == MDU_REM);
        b_sgn     = (io.op == MDU_MULH) || (io.op == MDU_DIV) || (io.op == MDU_REM);
        neg_a     = a_sgn && io.a[XLEN-1];
        neg_b     = b_sgn && io.b[XLEN-1];
        mag_a     = neg_a ? -io.a : io.a;
        mag_b     = neg_b ? -io.b : io.b;
        div0      = io.op[2] && (io.b == '0);
        ovf       = io.op[2] && !io.op[0] && (io.a == MOST_NEG) && (io.b == ALL_ONES);
        special   = div0 || ovf || (!io.op[2] && (FAST_MUL != 0));
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        if (div0) begin
            spec_res = io.op[1] ? io.a : ALL_ONES;
        end else if (ovf) begin
            spec_res = io.op[1] ? '0 : io.a;
        end else begin
            spec_res = fix_sign(io.op, neg_a ^ neg_b, neg_a, fast_prod);
        end
    end

    // Next state; flush overrides everything, including a start in the same cycle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (io.start && !io.flush) begin
                    accept    = 1'b1;
                    state_nxt = special ? MDU_DONE : MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (!io.flush && (cnt == '0)) begin
                    finish    = 1'b1;
                    state_nxt = MDU_DONE;
                end
            end
            MDU_DONE: state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
        if (io.flush) begin
            state_nxt = MDU_IDLE;
        end
    end

    assign step = (state == MDU_CALC) && !io.flush;
    assign load = accept && !special;
    assign mode = op_q[2] ? MDU_MODE_DIV : MDU_MODE_MUL;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration counter and the op/sign information captured at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            cnt   <= CW'(XLEN - 1);
            op_q  <= io.op;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
        end else if (step && (cnt != '0)) begin
            cnt   <= cnt - CW'(1);
        end
    end

    // Result register: written on entry to DONE only, so a flushed op leaves it untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (accept && special) begin
            result_q <= spec_res;
        end else if (finish) begin
            result_q <= fix_sign(op_q, neg_q, neg_r, acc_step);
        end
    end

    mdu_iter #(
        .XLEN     (XLEN)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .mode     (mode),
        .opa      (mag_a),
        .opb      (mag_b),
        .acc_step (acc_step)
    );

    assign io.stall  = io.start && (state != MDU_DONE);
    assign io.busy   = (state == MDU_CALC);
    assign io.done   = (state == MDU_DONE);
    assign io.result = result_q;

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Iterative multiply/divide unit for the RV32M extension, sitting beside the combinational ALU in the execute stage. It receives already-forwarded operands, holds the pipeline through a stall output while it computes, and presents a registered result with a one-cycle done pulse. It is parametrised in data width and in multiply mode (iterative or single-cycle). Division is always iterative.

## Interface
- XLEN, 32: operand and result width; must be at least 8.
- FAST_MUL, 0: 0 computes multiplies iteratively in XLEN cycles; 1 computes them in a single cycle.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  level signal; the EX-stage instruction is an M-op; held while stall is high.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand, post-forwarding.
- b  in  XLEN  rs2 operand, post-forwarding.
- flush  in  1  synchronous abort of the in-flight op (branch taken or trap).
- stall  out  1  combinational; equals start && state!=DONE.
- busy  out  1  registered; high in CALC.
- done  out  1  registered; high in DONE only.
- result  out  XLEN  registered; valid while done=1 and held until the next load.

## Operation
- States:
  - IDLE → CALC when start=1, no flush, and the op is not a special case.
  - IDLE → DONE when start=1 and the op is a special case.
  - CALC → DONE when the counter reaches 0.
  - DONE → IDLE unconditionally.
- Acceptance:
  - Operands and op are latched only on the IDLE → CALC/DONE transition.
  - Changes on a, b or op afterwards are ignored.
- Special cases, resolved in 1 cycle with no CALC:
  - Divide by zero: quotient = all-ones, remainder = a.
  - Signed overflow (a = most-negative value, b = −1, DIV or REM): quotient = a, remainder = 0.
  - Any multiply when FAST_MUL=1.
- Sign handling:
  - Signed operands are converted to magnitudes at accept. MULHSU treats a as signed and b as unsigned.
  - The product is 2·XLEN bits wide. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - The product is negated when the effective operand signs differ.
  - Quotient is negative when the signs differ; remainder takes the sign of the dividend. Correction is applied when loading result.
- Datapath:
  - Multiply is shift-add, one bit per cycle, using a 2·XLEN accumulator.
  - Divide is restoring, one quotient bit per cycle, using a (XLEN+1)-bit partial remainder.
  - Both share the accumulator/shift register.
- Counter:
  - Width is clog2(XLEN); loaded with XLEN−1 at accept; decrements each CALC cycle.
- flush:
  - In any state, forces IDLE on the next edge and suppresses done.
  - result is not updated.
  - flush has priority over start in the same cycle.
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0, accumulator 0.
- Reset mid-operation discards the op; no done is issued.

## Timing
- Start sampled in IDLE at cycle t.
- Iterative op:
  - CALC runs from t+1 to t+XLEN.
  - DONE (done=1, stall=0) is at t+XLEN+1.
  - The instruction leaves EX at the end of t+XLEN+1.
- Special-case or fast-multiply op: DONE is at t+1, so stall is high for 1 cycle.
- Back-to-back ops:
  - DONE is followed by IDLE.
  - A following M-op held on start is accepted in that IDLE cycle.
  - There is no lost or duplicate done.
- stall is 0 whenever start=0.

## Structure
- Shared package ex_pkg holds:
  - funct3 localparams (MDU_MUL … MDU_REMU).
  - State encoding (MDU_IDLE, MDU_CALC, MDU_DONE).
  - Special-case result constants derived from XLEN.
- One sub-module, mdu_iter, holds the shared shift/accumulate datapath:
  - Takes a mode input (mul or div) and a step enable.
  - The FSM, sign handling and result register stay in ex_mdu.

## Test plan
All scenarios use XLEN=32 unless stated otherwise.
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB. done exactly 33 cycles after start; stall high for 33 cycles.
- Multiply-high ops:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with done 1 cycle after start:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Abort and reset:
  - flush during CALC cycle 10 → IDLE next cycle; done never pulses; the next DIVU 9/3 returns 3 normally.
  - rst asserted asynchronously mid-CALC → busy, done and result read 0 immediately.
- FAST_MUL=1, two MULs held back-to-back (3×4 then 5×6) → done at t+1 with 12, then 30 after one IDLE cycle; exactly two done pulses.
